// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame FSM states, prefix byte values
// and the odd-parity helper used by the frame decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    // A PS/2 frame is valid when data plus parity carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronizes the raw PS/2 lines, debounces ps2_clk and emits a one-cycle
// pulse on every accepted falling edge of the filtered clock.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic clk_fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_filt;
    logic [CW-1:0] run_cnt;

    assign data_s = data_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_filt  <= 1'b1;
            run_cnt   <= '0;
            clk_fall  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_fall  <= 1'b0;
            // run_cnt counts consecutive samples that disagree with the filtered level
            if (clk_sync[1] == clk_filt) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                run_cnt  <= '0;
                clk_fall <= clk_filt;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: deserializes 11-bit frames and decodes make,
// break (F0) and extended (E0) sequences into a held key code.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       extended,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          data_s;
    logic          clk_fall;
    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic          break_pending;
    logic          ext_pending;

    ps2_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_sync_filter (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .data_s  (data_s),
        .clk_fall(clk_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            shift         <= '0;
            par_bit       <= 1'b0;
            tcnt          <= '0;
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
            key_code      <= 8'h00;
            key_valid     <= 1'b0;
            extended      <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            if (clk_fall) begin
                tcnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (!data_s) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift   <= {data_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= data_s;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (!data_s || !odd_parity_ok(shift, par_bit)) begin
                            frame_err     <= 1'b1;
                            break_pending <= 1'b0;
                            ext_pending   <= 1'b0;
                        end else if (shift == BREAK_CODE) begin
                            break_pending <= 1'b1;
                        end else if (shift == EXT_CODE) begin
                            ext_pending <= 1'b1;
                        end else begin
                            if (!break_pending) begin
                                key_code  <= shift;
                                extended  <= ext_pending;
                                key_valid <= 1'b1;
                            end else if (shift == key_code && ext_pending == extended) begin
                                key_code <= 8'h00;
                                extended <= 1'b0;
                            end
                            break_pending <= 1'b0;
                            ext_pending   <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                // A stalled device leaves a partial frame; abandon it after the timeout
                if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    tcnt          <= '0;
                    state         <= ST_IDLE;
                    frame_err     <= 1'b1;
                    break_pending <= 1'b0;
                    ext_pending   <= 1'b0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: directed PS/2 scenarios plus random byte
// streams checked against a byte-level decoding model.
module tb_ps2_scancode_rx;

    localparam int FLT  = 8;
    localparam int TMO  = 300;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_valid;
    logic       extended;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    int kv_cnt = 0, fe_cnt = 0, kv_long = 0, fe_long = 0;
    logic kv_prev = 1'b0, fe_prev = 1'b0;

    logic [7:0] m_code = 8'h00;
    logic       m_ext  = 1'b0;
    logic       m_brk  = 1'b0;
    logic       m_pext = 1'b0;

    ps2_scancode_rx #(
        .FILTER_LEN    (FLT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_code (key_code),
        .key_valid(key_valid),
        .extended (extended),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid) kv_cnt++;
        if (frame_err) fe_cnt++;
        if (key_valid && kv_prev) kv_long++;
        if (frame_err && fe_prev) fe_long++;
        kv_prev = key_valid;
        fe_prev = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte-level decoder: what the keyboard state should be after one frame.
    task automatic model_apply(input logic [7:0] b, input bit ok, output int ekv, output int efe);
        ekv = 0;
        efe = 0;
        if (!ok) begin
            efe = 1;
            m_brk = 1'b0;
            m_pext = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_pext = 1'b1;
        end else begin
            if (!m_brk) begin
                m_code = b;
                m_ext = m_pext;
                ekv = 1;
            end else if (b == m_code && m_pext == m_ext) begin
                m_code = 8'h00;
                m_ext = 1'b0;
            end
            m_brk = 1'b0;
            m_pext = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (bad_par ? ^b : ~^b), b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input string tag);
        int kv0, fe0, ekv, efe;
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        send_bits(b, bad_par, 11);
        repeat (30) @(negedge clk);
        model_apply(b, !bad_par, ekv, efe);
        check({tag, "_code"}, 32'(key_code), 32'(m_code));
        check({tag, "_ext"}, 32'(extended), 32'(m_ext));
        check({tag, "_kv"}, 32'(kv_cnt - kv0), 32'(ekv));
        check({tag, "_fe"}, 32'(fe_cnt - fe0), 32'(efe));
    endtask

    initial begin
        int kv0, fe0, ekv, efe, kind;
        logic [7:0] codes [4];
        logic [7:0] b;
        codes[0] = 8'h1C; codes[1] = 8'h1B; codes[2] = 8'h5A; codes[3] = 8'h79;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_code", 32'(key_code), 32'h00);
        check("rst_kv", 32'(key_valid), 32'h0);
        check("rst_ext", 32'(extended), 32'h0);
        check("rst_fe", 32'(frame_err), 32'h0);

        frame(8'h79, 1'b0, "make79");
        frame(8'hF0, 1'b0, "brk_f0");
        frame(8'h79, 1'b0, "brk_79");
        frame(8'hF0, 1'b0, "brk2_f0");
        frame(8'h7B, 1'b0, "brk2_7b");

        frame(8'hE0, 1'b0, "ext_e0");
        frame(8'h5A, 1'b0, "ext_5a");
        frame(8'hE0, 1'b0, "extbrk_e0");
        frame(8'hF0, 1'b0, "extbrk_f0");
        frame(8'h5A, 1'b0, "extbrk_5a");

        frame(8'h1C, 1'b0, "pre_1c");
        frame(8'h7B, 1'b1, "badpar_7b");
        frame(8'h1C, 1'b0, "repeat_1c");

        kv0 = kv_cnt;
        fe0 = fe_cnt;
        send_bits(8'h33, 1'b0, 6);
        repeat (TMO + 10) @(negedge clk);
        model_apply(8'h00, 1'b0, ekv, efe);
        check("tmo_fe", 32'(fe_cnt - fe0), 32'(efe));
        check("tmo_kv", 32'(kv_cnt - kv0), 32'h0);
        frame(8'h7C, 1'b0, "after_tmo");

        kv0 = kv_cnt;
        fe0 = fe_cnt;
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (TMO + 40) @(negedge clk);
        check("glitch_fe", 32'(fe_cnt - fe0), 32'h0);
        check("glitch_kv", 32'(kv_cnt - kv0), 32'h0);
        check("glitch_code", 32'(key_code), 32'(m_code));
        frame(8'h1B, 1'b0, "after_glitch");

        frame(8'h79, 1'b0, "pre_rst");
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        send_bits(8'h79, 1'b0, 6);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_code = 8'h00; m_ext = 1'b0; m_brk = 1'b0; m_pext = 1'b0;
        repeat (TMO + 20) @(negedge clk);
        check("midrst_code", 32'(key_code), 32'h00);
        check("midrst_ext", 32'(extended), 32'h0);
        check("midrst_kv", 32'(kv_cnt - kv0), 32'h0);
        check("midrst_fe", 32'(fe_cnt - fe0), 32'h0);
        frame(8'h7C, 1'b0, "after_rst");

        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 9));
            b = codes[$urandom_range(0, 3)];
            if (kind <= 1) frame(8'hF0, 1'b0, $sformatf("rnd%0d", i));
            else if (kind == 2) frame(8'hE0, 1'b0, $sformatf("rnd%0d", i));
            else if (kind == 3) frame(b, 1'b1, $sformatf("rnd%0d", i));
            else frame(b, 1'b0, $sformatf("rnd%0d", i));
        end

        check("kv_width", 32'(kv_long), 32'h0);
        check("fe_width", 32'(fe_long), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
